select_encode_seq: RTL and testbench

SELECT_ENCODE_SEQ -- requirements
Module: select_encode_seq

---
 rtl/select_encode_seq_if.sv | 49 ++++
 rtl/select_encode_seq.sv | 194 +++++++++++++++++++
 tb/tb_select_encode_seq.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/select_encode_seq_if.sv
// Bus bundle for select_encode_seq: IR load, sequence start, manual select
// controls and the decoded register enables. Optional base_zero under R0_ZERO_EN.
interface select_encode_seq_if #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32
);
  logic                ir_load;
  logic [DATA_W-1:0]   instruction;
  logic                start;
  logic [1:0]          seq_mode;
  logic                Gra;
  logic                Grb;
  logic                Grc;
  logic                Rin;
  logic                Rout;
  logic                BAout;
  logic                busy;
  logic                done;
  logic [NUM_REGS-1:0] ctrl_in;
  logic [NUM_REGS-1:0] ctrl_out;
  logic [DATA_W-1:0]   Cdata;
`ifdef R0_ZERO_EN
  logic                base_zero;

  modport master (
    output ir_load, instruction, start, seq_mode,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    input  busy, done, ctrl_in, ctrl_out, Cdata, base_zero
  );

  modport slave (
    input  ir_load, instruction, start, seq_mode,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    output busy, done, ctrl_in, ctrl_out, Cdata, base_zero
  );
`else
  modport master (
    output ir_load, instruction, start, seq_mode,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    input  busy, done, ctrl_in, ctrl_out, Cdata
  );

  modport slave (
    input  ir_load, instruction, start, seq_mode,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    output busy, done, ctrl_in, ctrl_out, Cdata
  );
`endif
endinterface

// File: rtl/select_encode_seq.sv
// Register select/encode sequencer: decodes Ra/Rb/Rc from an internal IR into
// one-hot read/write enables, manually or via ALU/LOAD/STORE sequences.
// Optional feature macro R0_ZERO_EN: base-address reads of R0 yield base_zero.
module select_encode_seq #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 19,
  parameter int RA_LSB   = 23,
  parameter int RB_LSB   = 19,
  parameter int RC_LSB   = 15
) (
  input  logic                 clock,
  input  logic                 clear,
  select_encode_seq_if.slave   bus
);

  localparam int RW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SRC1 = 3'd1,
    S_SRC2 = 3'd2,
    S_DEST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    M_RSVD  = 2'b00,
    M_ALU   = 2'b01,
    M_LOAD  = 2'b10,
    M_STORE = 2'b11
  } mode_t;

  state_t              state, state_nxt;
  mode_t               mode, mode_nxt;
  logic [DATA_W-1:0]   ir;
  logic [DATA_W-1:0]   ir_eff;
  logic                ir_we;
  logic [RW-1:0]       ra, rb, rc;
  logic [RW-1:0]       man_idx;

  logic [NUM_REGS-1:0] ctrl_in_q, ctrl_out_q;
  logic [NUM_REGS-1:0] ctrl_in_nxt, ctrl_out_nxt;
  logic                base_zero_nxt;

  // Decode intent for the state being entered on the next edge.
  logic                wr_en, rd_en, rd_ba;
  logic [RW-1:0]       wr_idx, rd_idx;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [RW-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // A load coinciding with start must steer the sequence from the new word,
  // so IDLE decisions see the incoming instruction rather than the stale IR.
  assign ir_we  = (state == S_IDLE) && bus.ir_load;
  assign ir_eff = ir_we ? bus.instruction : ir;

  assign ra = ir_eff[RA_LSB +: RW];
  assign rb = ir_eff[RB_LSB +: RW];
  assign rc = ir_eff[RC_LSB +: RW];

  assign man_idx = ({RW{bus.Gra}} & ra) | ({RW{bus.Grb}} & rb) | ({RW{bus.Grc}} & rc);

  // Only the register fields and the immediate are decoded from the IR.
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_eff;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    wr_en     = 1'b0;
    wr_idx    = '0;
    rd_en     = 1'b0;
    rd_idx    = '0;
    rd_ba     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.start && (mode_t'(bus.seq_mode) != M_RSVD)) begin
          // start wins over manual controls on the same edge
          state_nxt = S_SRC1;
          mode_nxt  = mode_t'(bus.seq_mode);
          rd_en     = 1'b1;
          rd_idx    = rb;
          rd_ba     = (mode_t'(bus.seq_mode) != M_ALU);
        end else begin
          wr_en  = bus.Rin;
          wr_idx = man_idx;
          rd_en  = bus.Rout | bus.BAout;
          rd_idx = man_idx;
          rd_ba  = bus.BAout;
        end
      end

      S_SRC1: begin
        unique case (mode)
          M_ALU: begin
            state_nxt = S_SRC2;
            rd_en     = 1'b1;
            rd_idx    = rc;
          end
          M_LOAD: begin
            state_nxt = S_DEST;
            wr_en     = 1'b1;
            wr_idx    = ra;
          end
          M_STORE: begin
            state_nxt = S_SRC2;
            rd_en     = 1'b1;
            rd_idx    = ra;
          end
          default: state_nxt = S_IDLE;
        endcase
      end

      S_SRC2: begin
        if (mode == M_ALU) begin
          state_nxt = S_DEST;
          wr_en     = 1'b1;
          wr_idx    = ra;
        end else begin
          state_nxt = S_DONE;
        end
      end

      S_DEST:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ctrl_in_nxt   = wr_en ? onehot(wr_idx) : '0;
    ctrl_out_nxt  = rd_en ? onehot(rd_idx) : '0;
    base_zero_nxt = 1'b0;
`ifdef R0_ZERO_EN
    if (rd_en && rd_ba && (rd_idx == '0)) begin
      ctrl_out_nxt  = '0;
      base_zero_nxt = 1'b1;
    end
`else
    base_zero_nxt = rd_ba & 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= S_IDLE;
      mode       <= M_RSVD;
      ir         <= '0;
      ctrl_in_q  <= '0;
      ctrl_out_q <= '0;
    end else begin
      state      <= state_nxt;
      mode       <= mode_nxt;
      ctrl_in_q  <= ctrl_in_nxt;
      ctrl_out_q <= ctrl_out_nxt;
      if (ir_we) begin
        ir <= bus.instruction;
      end
    end
  end

`ifdef R0_ZERO_EN
  logic base_zero_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      base_zero_q <= 1'b0;
    end else begin
      base_zero_q <= base_zero_nxt;
    end
  end

  assign bus.base_zero = base_zero_q;
`else
  logic unused_base_zero;
  assign unused_base_zero = base_zero_nxt;
`endif

  assign bus.ctrl_in  = ctrl_in_q;
  assign bus.ctrl_out = ctrl_out_q;
  assign bus.busy     = (state != S_IDLE);
  assign bus.done     = (state == S_DONE);
  assign bus.Cdata    = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

endmodule

// File: tb/tb_select_encode_seq.sv
// Directed self-checking bench for select_encode_seq with hand-computed vectors.
// Builds with or without R0_ZERO_EN; expectations follow the macro.
module tb_select_encode_seq;

  logic clock;
  logic clear;
  int   n_vec  = 0;
  int   n_miss = 0;

  select_encode_seq_if #(.NUM_REGS(16), .DATA_W(32)) bus ();

  select_encode_seq dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    bus.ir_load  = 1'b0;
    bus.start    = 1'b0;
    bus.seq_mode = 2'b00;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.BAout    = 1'b0;
  endtask

  task automatic load_ir(input logic [31:0] word);
    bus.ir_load     = 1'b1;
    bus.instruction = word;
    tick();
    bus.ir_load     = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [15:0] cin, input logic [15:0] cout,
                            input logic busy, input logic done);
    check({tag, ".ctrl_in"},  64'(bus.ctrl_in),  64'(cin));
    check({tag, ".ctrl_out"}, 64'(bus.ctrl_out), 64'(cout));
    check({tag, ".busy"},     64'(bus.busy),     64'(busy));
    check({tag, ".done"},     64'(bus.done),     64'(done));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    quiet();
    bus.instruction = 32'hFFFF_FFFF;
    clear = 1'b1;
    tick();
    tick();
    expect_out("reset", 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("reset.Cdata", 64'(bus.Cdata), 64'h0);
`ifdef R0_ZERO_EN
    check("reset.base_zero", 64'(bus.base_zero), 64'h0);
`endif
    clear = 1'b0;

    // Ra=3 Rb=5 Rc=7, imm = 0x38000
    load_ir(32'h01AB_8000);
    check("ir.Cdata", 64'(bus.Cdata), 64'h0003_8000);

    // Manual: Grb + Rout -> read R5
    bus.Grb = 1'b1; bus.Rout = 1'b1;
    tick();
    quiet();
    expect_out("man_rb", 16'h0000, 16'h0020, 1'b0, 1'b0);
    tick();
    expect_out("man_none", 16'h0000, 16'h0000, 1'b0, 1'b0);

    // Manual: Gra|Grb = 3|5 = 7, write
    bus.Gra = 1'b1; bus.Grb = 1'b1; bus.Rin = 1'b1;
    tick();
    quiet();
    expect_out("man_or", 16'h0080, 16'h0000, 1'b0, 1'b0);

    // Manual: no Gr -> index 0
    bus.Rin = 1'b1;
    tick();
    quiet();
    expect_out("man_r0", 16'h0001, 16'h0000, 1'b0, 1'b0);

    // ALU sequence; manual controls on the start edge are ignored
    bus.start = 1'b1; bus.seq_mode = 2'b01; bus.Grc = 1'b1; bus.Rin = 1'b1;
    tick();
    quiet();
    expect_out("alu.src1", 16'h0000, 16'h0020, 1'b1, 1'b0);
    // start, ir_load and manual inputs while busy are all ignored
    bus.start = 1'b1; bus.seq_mode = 2'b11; bus.ir_load = 1'b1;
    bus.instruction = 32'h0000_0000; bus.Gra = 1'b1; bus.Rin = 1'b1;
    tick();
    quiet();
    expect_out("alu.src2", 16'h0000, 16'h0080, 1'b1, 1'b0);
    tick();
    expect_out("alu.dest", 16'h0008, 16'h0000, 1'b1, 1'b0);
    tick();
    expect_out("alu.done", 16'h0000, 16'h0000, 1'b1, 1'b1);
    tick();
    expect_out("alu.idle", 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    expect_out("alu.no_restart", 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("busy_load.Cdata", 64'(bus.Cdata), 64'h0003_8000);

    // Immediate sign extension boundaries
    load_ir(32'h0004_0000);
    check("cdata.neg", 64'(bus.Cdata), 64'hFFFC_0000);
    load_ir(32'h0003_FFFF);
    check("cdata.pos", 64'(bus.Cdata), 64'h0003_FFFF);

    // LOAD with ir_load on the start edge: uses the incoming word
    bus.ir_load = 1'b1; bus.instruction = 32'h01AB_8000;
    bus.start = 1'b1; bus.seq_mode = 2'b10;
    tick();
    quiet();
    expect_out("load.src1", 16'h0000, 16'h0020, 1'b1, 1'b0);
`ifdef R0_ZERO_EN
    check("load.src1.base_zero", 64'(bus.base_zero), 64'h0);
`endif
    tick();
    expect_out("load.dest", 16'h0008, 16'h0000, 1'b1, 1'b0);
    tick();
    expect_out("load.done", 16'h0000, 16'h0000, 1'b1, 1'b1);
    tick();
    expect_out("load.idle", 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("load.Cdata", 64'(bus.Cdata), 64'h0003_8000);

    // STORE: read Rb then Ra, never write
    bus.start = 1'b1; bus.seq_mode = 2'b11;
    tick();
    quiet();
    expect_out("store.src1", 16'h0000, 16'h0020, 1'b1, 1'b0);
    tick();
    expect_out("store.src2", 16'h0000, 16'h0008, 1'b1, 1'b0);
    tick();
    expect_out("store.done", 16'h0000, 16'h0000, 1'b1, 1'b1);
    tick();
    expect_out("store.idle", 16'h0000, 16'h0000, 1'b0, 1'b0);

    // clear during SRC2 aborts the sequence without done
    bus.start = 1'b1; bus.seq_mode = 2'b01;
    tick();
    quiet();
    tick();
    expect_out("abort.src2", 16'h0000, 16'h0080, 1'b1, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    expect_out("abort.cleared", 16'h0000, 16'h0000, 1'b0, 1'b0);
    check("abort.Cdata", 64'(bus.Cdata), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("abort.quiet", 16'h0000, 16'h0000, 1'b0, 1'b0);
    end

    // LOAD with Rb=0 (Ra=3)
    load_ir(32'h0180_0000);
    bus.start = 1'b1; bus.seq_mode = 2'b10;
    tick();
    quiet();
`ifdef R0_ZERO_EN
    expect_out("r0.src1", 16'h0000, 16'h0000, 1'b1, 1'b0);
    check("r0.src1.base_zero", 64'(bus.base_zero), 64'h1);
`else
    expect_out("r0.src1", 16'h0000, 16'h0001, 1'b1, 1'b0);
`endif
    tick();
    expect_out("r0.dest", 16'h0008, 16'h0000, 1'b1, 1'b0);
`ifdef R0_ZERO_EN
    check("r0.dest.base_zero", 64'(bus.base_zero), 64'h0);
`endif
    tick();
    expect_out("r0.done", 16'h0000, 16'h0000, 1'b1, 1'b1);
    tick();

    // Reserved mode: start ignored
    bus.start = 1'b1; bus.seq_mode = 2'b00;
    tick();
    quiet();
    expect_out("rsvd", 16'h0000, 16'h0000, 1'b0, 1'b0);
    tick();
    expect_out("rsvd.after", 16'h0000, 16'h0000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
